game_timer: RTL



---
 rtl/game_timer_if.sv | 27 ++
 rtl/game_timer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/game_timer_if.sv
// Signal bundle between the game state machine (master) and game_timer (slave).
// add_time_pulse is only present when BONUS_TIME_EN is defined.
interface game_timer_if;
   logic       game_on;
   logic       pause;
`ifdef BONUS_TIME_EN
   logic       add_time_pulse;
`endif
   logic       one_sec_pulse;
   logic       timer_ended;
   logic       warning;
   logic [3:0] minutes;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;

`ifdef BONUS_TIME_EN
   modport master (output game_on, pause, add_time_pulse,
                   input  one_sec_pulse, timer_ended, warning, minutes, sec_tens, sec_ones);
   modport slave  (input  game_on, pause, add_time_pulse,
                   output one_sec_pulse, timer_ended, warning, minutes, sec_tens, sec_ones);
`else
   modport master (output game_on, pause,
                   input  one_sec_pulse, timer_ended, warning, minutes, sec_tens, sec_ones);
   modport slave  (input  game_on, pause,
                   output one_sec_pulse, timer_ended, warning, minutes, sec_tens, sec_ones);
`endif
endinterface

// File: rtl/game_timer.sv
// Round timer: free-running 1 s prescaler plus a BCD m:ss countdown with pause and end hold.
// Optional macro BONUS_TIME_EN adds a saturating bonus-seconds adder on add_time_pulse.
module game_timer #(
   parameter int CLK_FREQ      = 31500000,
   parameter int START_SECONDS = 180,
   parameter int WARN_SECONDS  = 10,
   parameter int BONUS_SECONDS = 15
) (
   input  logic        clk,
   input  logic        resetN,
   game_timer_if.slave bus
);
   localparam int              CNT_W     = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_FREQ - 1);
   localparam logic [11:0]     START_BCD = {4'(START_SECONDS / 60),
                                            4'((START_SECONDS % 60) / 10),
                                            4'(START_SECONDS % 10)};

   typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, ENDED} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] presc_reg;
   logic             pulse_reg;
   logic             game_on_d_reg;
   logic             ended_reg, ended_next;
   logic             warning_reg, warning_next;
   logic [11:0]      digits_reg, digits_next;

   logic        tick, rise, bonus_now, hit_zero;
   logic [9:0]  rem_secs;
   logic [11:0] dec_val;

   // Borrowing BCD decrement of {minutes, tens, ones}.
   function automatic logic [11:0] bcd_dec(input logic [11:0] v);
      logic [3:0] m, t, o;
      {m, t, o} = v;
      if (o != 4'd0) begin
         o = o - 4'd1;
      end else begin
         o = 4'd9;
         if (t != 4'd0) begin
            t = t - 4'd1;
         end else begin
            t = 4'd5;
            m = m - 4'd1;
         end
      end
      return {m, t, o};
   endfunction

   assign tick     = (presc_reg == CNT_MAX);
   assign rise     = bus.game_on & ~game_on_d_reg;
   assign dec_val  = bcd_dec(digits_reg);
   assign rem_secs = 10'(digits_reg[11:8]) * 10'd60 + 10'(digits_reg[7:4]) * 10'd10
                   + 10'(digits_reg[3:0]);

`ifdef BONUS_TIME_EN
   logic [10:0] add_sum;
   logic [11:0] add_plain, add_dec;

   function automatic logic [9:0] sat599(input logic [10:0] s);
      return (s > 11'd599) ? 10'd599 : s[9:0];
   endfunction

   function automatic logic [11:0] to_bcd(input logic [9:0] s);
      logic [3:0] mm, tt;
      logic [9:0] r;
      mm = 4'(s / 10'd60);
      r  = s - 10'(mm) * 10'd60;
      tt = 4'(r / 10'd10);
      return {mm, tt, 4'(r - 10'(tt) * 10'd10)};
   endfunction

   assign bonus_now = bus.add_time_pulse;
   assign add_sum   = 11'(rem_secs) + 11'(BONUS_SECONDS);
   assign add_plain = to_bcd(sat599(add_sum));
   // A bonus landing on a tick also absorbs that tick's decrement.
   assign add_dec   = to_bcd(sat599(add_sum - 11'd1));
`else
   assign bonus_now = 1'b0;
`endif

   assign hit_zero = (state_reg == RUNNING) && bus.game_on && !bus.pause && tick
                   && !bonus_now && (dec_val == 12'h000);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_reg     <= IDLE;
         presc_reg     <= '0;
         pulse_reg     <= 1'b0;
         game_on_d_reg <= 1'b0;
         ended_reg     <= 1'b0;
         warning_reg   <= 1'b0;
         digits_reg    <= 12'h000;
      end else begin
         state_reg     <= state_next;
         presc_reg     <= tick ? '0 : presc_reg + 1'b1;
         pulse_reg     <= tick;
         game_on_d_reg <= bus.game_on;
         ended_reg     <= ended_next;
         warning_reg   <= warning_next;
         digits_reg    <= digits_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (rise) state_next = RUNNING;
         RUNNING: begin
            if (!bus.game_on)  state_next = IDLE;
            else if (bus.pause) state_next = PAUSED;
            else if (hit_zero)  state_next = ENDED;
         end
         PAUSED: begin
            if (!bus.game_on)   state_next = IDLE;
            else if (!bus.pause) state_next = RUNNING;
         end
         ENDED:   if (!bus.game_on) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      digits_next  = digits_reg;
      ended_next   = ended_reg;
      warning_next = ((state_reg == RUNNING) || (state_reg == PAUSED))
                   && (rem_secs != 10'd0) && (rem_secs <= 10'(WARN_SECONDS));
      case (state_reg)
         IDLE: begin
            if (rise) begin
               digits_next = START_BCD;
               ended_next  = 1'b0;
            end
         end
         RUNNING: begin
            if (bus.game_on && !bus.pause && tick) digits_next = dec_val;
            if (hit_zero) ended_next = 1'b1;
         end
         ENDED:   if (!bus.game_on) ended_next = 1'b0;
         default: ;
      endcase
`ifdef BONUS_TIME_EN
      if (bonus_now && bus.game_on && ((state_reg == RUNNING) || (state_reg == PAUSED)))
         digits_next = ((state_reg == RUNNING) && !bus.pause && tick) ? add_dec : add_plain;
`endif
   end

   assign bus.one_sec_pulse = pulse_reg;
   assign bus.timer_ended   = ended_reg;
   assign bus.warning       = warning_reg;
   assign bus.minutes       = digits_reg[11:8];
   assign bus.sec_tens      = digits_reg[7:4];
   assign bus.sec_ones      = digits_reg[3:0];
endmodule
